// File: rtl/loba_seq_pkg.sv
// Shared types and constants for the windowed approximate sequential multiplier.
// Building with LOBA_SEQ_MULT_LL_TERM_EN adds the low*low term state.
package loba_seq_pkg;

    localparam int unsigned N_W = 16;
    localparam int unsigned M_W = 4;

    typedef logic signed [6:0] exp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPLIT,
        S_HH,
        S_HL,
        S_LH,
`ifdef LOBA_SEQ_MULT_LL_TERM_EN
        S_LL,
`endif
        S_DONE
    } state_t;

    // Net shift applied to a window product: ea + eb - 2M.
    function automatic exp_t shift_amt(input exp_t ea, input exp_t eb);
        return ea + eb - exp_t'(8);
    endfunction

endpackage

// File: rtl/loba_seq_split.sv
// Leading-one detection and high/low window extraction for one operand.
// Zero operands yield zero windows and zero exponents.
module loba_seq_split
    import loba_seq_pkg::*;
#(
    parameter int unsigned N = N_W,
    parameter int unsigned M = M_W
) (
    input  logic [N-1:0] x,
    output logic [M-1:0] hi,
    output logic [M-1:0] lo,
    output exp_t         e_hi,
    output exp_t         e_lo
);

    localparam int unsigned XW = N + M;
    localparam int unsigned KW = $clog2(XW);
    localparam int unsigned PW = 2 * M;
    localparam int unsigned WW = XW + PW - 1;

    logic [XW-1:0] xs;
    logic [WW-1:0] w;
    logic [KW-1:0] k;
    logic [PW-1:0] win;

    always_comb begin
        xs = {x, {M{1'b0}}};
        // Zero padding below bit 0 makes negative window indices read as 0.
        w  = {xs, {(PW-1){1'b0}}};
        k  = '0;
        for (int unsigned i = 0; i < XW; i++) begin
            if (xs[i]) k = KW'(i);
        end
        win  = PW'(w >> k);
        hi   = win[PW-1:M];
        lo   = win[M-1:0];
        e_hi = exp_t'(k) - exp_t'(M - 1);
        e_lo = e_hi - exp_t'(M);
        if (x == '0) begin
            hi   = '0;
            lo   = '0;
            e_hi = '0;
            e_lo = '0;
        end
    end

endmodule

// File: rtl/loba_seq_mult.sv
// Approximate unsigned multiplier: one registered MxM multiplier time-shared over
// the HH, HL, LH (and LL with LOBA_SEQ_MULT_LL_TERM_EN) window terms.
module loba_seq_mult
    import loba_seq_pkg::*;
#(
    parameter int unsigned N = N_W,
    parameter int unsigned M = M_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P,
    output logic           busy
);

    state_t state_q, state_d;
    logic   rdy_q;

    logic [N-1:0] a_q, b_q;
    logic [M-1:0] ah_q, al_q, bh_q, bl_q;
    exp_t         eah_q, eal_q, ebh_q, ebl_q;

    logic [M-1:0] sa_hi, sa_lo, sb_hi, sb_lo;
    exp_t         sa_eh, sa_el, sb_eh, sb_el;

    logic [M-1:0]   ma_q, mb_q, op_a, op_b;
    exp_t           sh_q, op_s, neg;
    logic [2*M-1:0] prod;
    logic [2*N-1:0] wide, term, acc_q;
    logic           acc_en;

    loba_seq_split #(.N(N), .M(M)) u_split_a (
        .x    (a_q),
        .hi   (sa_hi),
        .lo   (sa_lo),
        .e_hi (sa_eh),
        .e_lo (sa_el)
    );

    loba_seq_split #(.N(N), .M(M)) u_split_b (
        .x    (b_q),
        .hi   (sb_hi),
        .lo   (sb_lo),
        .e_hi (sb_eh),
        .e_lo (sb_el)
    );

    // Operands for the next term are staged one state ahead so the
    // multiplier input register feeds the accumulator in the term's own state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        acc_en    = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_s      = '0;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = rdy_q;
                if (in_valid && rdy_q) state_d = S_SPLIT;
            end
            S_SPLIT: begin
                state_d = S_HH;
                op_a    = sa_hi;
                op_b    = sb_hi;
                op_s    = shift_amt(sa_eh, sb_eh);
            end
            S_HH: begin
                state_d = S_HL;
                acc_en  = 1'b1;
                op_a    = ah_q;
                op_b    = bl_q;
                op_s    = shift_amt(eah_q, ebl_q);
            end
            S_HL: begin
                state_d = S_LH;
                acc_en  = 1'b1;
                op_a    = al_q;
                op_b    = bh_q;
                op_s    = shift_amt(eal_q, ebh_q);
            end
            S_LH: begin
                acc_en = 1'b1;
`ifdef LOBA_SEQ_MULT_LL_TERM_EN
                state_d = S_LL;
                op_a    = al_q;
                op_b    = bl_q;
                op_s    = shift_amt(eal_q, ebl_q);
`else
                state_d = S_DONE;
`endif
            end
`ifdef LOBA_SEQ_MULT_LL_TERM_EN
            S_LL: begin
                acc_en  = 1'b1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prod = ma_q * mb_q;
        wide = {{(2*N-2*M){1'b0}}, prod};
        neg  = -sh_q;
        term = (sh_q < exp_t'(0)) ? (wide >> neg) : (wide << sh_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ah_q    <= '0;
            al_q    <= '0;
            bh_q    <= '0;
            bl_q    <= '0;
            eah_q   <= '0;
            eal_q   <= '0;
            ebh_q   <= '0;
            ebl_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            ma_q    <= op_a;
            mb_q    <= op_b;
            sh_q    <= op_s;
            if (in_valid && in_ready) begin
                a_q   <= A;
                b_q   <= B;
                acc_q <= '0;
            end
            if (state_q == S_SPLIT) begin
                ah_q  <= sa_hi;
                al_q  <= sa_lo;
                bh_q  <= sb_hi;
                bl_q  <= sb_lo;
                eah_q <= sa_eh;
                eal_q <= sa_el;
                ebh_q <= sb_eh;
                ebl_q <= sb_el;
            end
            if (acc_en) acc_q <= acc_q + term;
        end
    end

    assign P = acc_q;

endmodule

// File: tb/tb_loba_seq_mult.sv
// Scoreboard bench for loba_seq_mult; honours LOBA_SEQ_MULT_LL_TERM_EN for
// expected latency and products.
module tb_loba_seq_mult;

`ifdef LOBA_SEQ_MULT_LL_TERM_EN
    localparam int          LAT      = 6;
    localparam logic [31:0] EXP_FFFF = 32'd4261478400;
`else
    localparam int          LAT      = 5;
    localparam logic [31:0] EXP_FFFF = 32'd4246732800;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] A, B;
    logic [31:0] P;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    loba_seq_mult #(.N(16), .M(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void split_m(input logic [15:0] x, output longint h, output longint l,
                                    output int eh, output int el);
        longint xp;
        int     k;
        h = 0; l = 0; eh = 0; el = 0;
        if (x != 16'd0) begin
            xp = longint'(x) * 16;
            k  = 0;
            for (int i = 0; i < 20; i++) if (xp[i]) k = i;
            h  = (xp >> (k - 3)) & 15;
            l  = ((xp * 128) >> k) & 15;
            eh = k - 3;
            el = k - 7;
        end
    endfunction

    function automatic longint term_m(input longint ta, input longint tb, input int s);
        return ((ta * tb) << 32) >> (32 - s);
    endfunction

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        longint ah, al, bh, bl, sum;
        int     eah, eal, ebh, ebl;
        if (a == 16'd0 || b == 16'd0) return 32'd0;
        split_m(a, ah, al, eah, eal);
        split_m(b, bh, bl, ebh, ebl);
        sum = term_m(ah, bh, eah + ebh - 8) + term_m(ah, bl, eah + ebl - 8)
            + term_m(al, bh, eal + ebh - 8);
`ifdef LOBA_SEQ_MULT_LL_TERM_EN
        sum += term_m(al, bl, eal + ebl - 8);
`endif
        return sum[31:0];
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p,
                          input int hold, input string tag);
        int          cyc;
        logic [31:0] exp_q;
        cyc = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; in_valid = 1'b1;
        sb_q.push_back(exp_p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        cyc = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_no_accept_done"}, 32'(in_ready), 32'd0);
        check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        exp_q = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_P"}, P, exp_q);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_P"}, P, exp_q);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [15:0] ra, rb;
        int          cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_P", P, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        run_op(16'd1, 16'd1, 32'd1, 0, "one");
        run_op(16'd3, 16'd5, 32'd15, 0, "three_five");
        run_op(16'h00FF, 16'h00FF, 32'd64800, 0, "ff");
        run_op(16'hFFFF, 16'hFFFF, EXP_FFFF, 0, "ffff");
        run_op(16'h1234, 16'h0ABC, model(16'h1234, 16'h0ABC), 10, "hold");
        run_op(16'h0000, 16'h1234, 32'd0, 0, "zero");
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, model(ra, rb), 0, "rand");
        end

        // Abort an operation while it is in HL.
        @(negedge clk);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        A = 16'd7; B = 16'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_busy_hl", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_P", P, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_op(16'd3, 16'd5, 32'd15, 0, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/loba_seq_mult.md
LOBA_SEQ_MULT -- requirements
Module: loba_seq_mult

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits; only 16 is supported.
REQ-002 SHALL have parameter M, default 4, window width in bits; only 4 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  operands A/B are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port A  input  N  unsigned multiplicand.
REQ-008 SHALL have port B  input  N  unsigned multiplier.
REQ-009 SHALL have port out_valid  output  1  P holds a finished product.
REQ-010 SHALL have port out_ready  input  1  consumer takes P.
REQ-011 SHALL have port P  output  2N  approximate product.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL time-share one registered MxM unsigned multiplier across all partial-product terms; no other multiplier instance.
REQ-014 SHALL split each operand X as follows:
- X' = X<<4 (20 bits); k = index of the leading one in X'.
- Xh = X'[k:k-3]; Xl = X'[k-4:k-7]; any negative bit index reads as 0.
- eh = k-3; el = eh-4 (signed).
REQ-015 SHALL form each term Ta*Tb shifted by s = ea+eb-8: left shift if s>=0, truncating right shift if s<0; accumulate into a 2N-bit register.
REQ-016 SHALL run the terms in the order HH, HL (Ah*Bl), LH (Al*Bh), one term per cycle.
REQ-017 SHALL produce P=0 when either operand is 0; zero-operand cases still traverse all states.
REQ-018 SHALL use the states IDLE, SPLIT, HH, HL, LH, DONE.
REQ-019 SHALL make the following transitions:
- IDLE->SPLIT on in_valid&&in_ready; operands are captured on this edge.
- SPLIT->HH->HL->LH unconditionally, one cycle each.
- LH->DONE.
- DONE->IDLE on out_ready.
REQ-020 SHALL drive in_ready=1 only in IDLE; no accept in the same cycle as the DONE->IDLE transition.
REQ-021 SHALL hold out_valid=1 and P stable in DONE until out_ready is sampled high.
REQ-022 SHALL assert out_valid exactly 5 cycles after the accepting edge when the optional term is disabled.
REQ-023 SHALL ignore A/B changes after capture.

Reset
REQ-024 SHALL, on rst_n low at any time (mid-operation included), immediately force state=IDLE, accumulator=0, P=0, out_valid=0, busy=0, in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first clock edge after rst_n deassertion.
REQ-026 SHALL discard any in-flight operation on reset, with no later out_valid for it.

Configuration
REQ-027 SHALL, with macro LOBA_SEQ_MULT_LL_TERM_EN defined, add state LL (Al*Bl) between LH and DONE, giving latency 6 cycles.
REQ-028 SHALL, without LOBA_SEQ_MULT_LL_TERM_EN, contain no LL state or logic; latency is 5 cycles.

Structure
REQ-029 SHALL place the state enum, the N/M constants and the signed exponent type in package loba_seq_pkg.
REQ-030 SHALL implement leading-one detection and windowing in sub-module loba_seq_split, instantiated once per operand.

Verification
REQ-031 SHALL cover A=1, B=1 -> P=1, out_valid 5 cycles after accept.
REQ-032 SHALL cover A=3, B=5 -> P=15.
REQ-033 SHALL cover A=0x00FF, B=0x00FF -> P=64800 (0xFD20).
REQ-034 SHALL cover A=0xFFFF, B=0xFFFF -> P=4246732800 without the macro and P=4261478400 with LOBA_SEQ_MULT_LL_TERM_EN (latency 6).
REQ-035 SHALL cover out_ready held low 10 cycles in DONE, then A=0, B=0x1234 -> P stable throughout, then P=0 after the second accept.
REQ-036 SHALL cover rst_n pulsed low during HL -> out_valid never rises for that operation, in_ready=1 after release, and the next operation is correct.
